// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NM masters share one slave bus, grant locked for a whole CYC.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that turns a stalled strobe into a one-cycle bus error.
module wb_rr_arbiter #(
  parameter int NM             = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NM*AW-1:0] wbm_adr_i,
  input  logic [NM*DW-1:0] wbm_dat_i,
  output logic [NM*DW-1:0] wbm_dat_o,
  input  logic [NM-1:0]    wbm_we_i,
  input  logic [NM*SW-1:0] wbm_sel_i,
  input  logic [NM-1:0]    wbm_stb_i,
  input  logic [NM-1:0]    wbm_cyc_i,
  output logic [NM-1:0]    wbm_ack_o,
  output logic [NM-1:0]    wbm_err_o,
  output logic [AW-1:0]    wbs_adr_o,
  output logic [DW-1:0]    wbs_dat_o,
  input  logic [DW-1:0]    wbs_dat_i,
  output logic             wbs_we_o,
  output logic [SW-1:0]    wbs_sel_o,
  output logic             wbs_stb_o,
  output logic             wbs_cyc_o,
  input  logic             wbs_ack_i,
  output logic [NM-1:0]    grant_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [IW-1:0] LAST = IW'(NM - 1);

  if (NM < 2 || NM > 8 || SW * 8 != DW || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_rr_arbiter: unsupported parameter combination");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [NM-1:0] grant, grant_next;
  logic [IW-1:0] owner, owner_next;
  logic [IW-1:0] prio_ptr, prio_ptr_next;
  logic          found;
  logic [IW-1:0] pick;
  logic          owner_cyc;
  logic          stb_raw;
  logic          timeout;

  // First requester found scanning upward from prio_ptr, wrapping at NM.
  always_comb begin
    int cand;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < NM; i++) begin
      cand = (int'(prio_ptr) + i) % NM;
      if (!found && wbm_cyc_i[cand]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign owner_cyc = (state == GRANT) && wbm_cyc_i[owner];
  assign stb_raw   = owner_cyc && wbm_stb_i[owner];
  assign grant_o   = grant;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      prio_ptr <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      owner    <= owner_next;
      prio_ptr <= prio_ptr_next;
    end
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    owner_next    = owner;
    prio_ptr_next = prio_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_next       = GRANT;
          owner_next       = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_cyc) begin
          state_next    = IDLE;
          grant_next    = '0;
          prio_ptr_next = (owner == LAST) ? '0 : owner + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux and master-side return paths; everything is quiet without a grant.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbm_dat_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (state == GRANT) begin
      wbs_adr_o                 = wbm_adr_i[owner*AW +: AW];
      wbs_dat_o                 = wbm_dat_i[owner*DW +: DW];
      wbs_we_o                  = wbm_we_i[owner];
      wbs_sel_o                 = wbm_sel_i[owner*SW +: SW];
      wbm_dat_o[owner*DW +: DW] = wbs_dat_i;
    end
    if (owner_cyc) begin
      wbm_ack_o[owner] = wbs_ack_i;
      wbm_err_o[owner] = timeout;
    end
  end

  assign wbs_cyc_o = owner_cyc;
  assign wbs_stb_o = stb_raw && !timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

  logic [CW-1:0] wd_cnt;

  // An ack in the limit cycle wins over the error.
  assign timeout = stb_raw && !wbs_ack_i && (wd_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state == IDLE) || wbs_ack_i || timeout) begin
      wd_cnt <= '0;
    end else if (stb_raw) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
